// File: rtl/calc3_pkg.sv
// Shared types and constants for the CALC3 request-port initiator.
// Holds command and response codes, the tag type, the request and response
// records, and a small priority helper used for tag selection.
package calc3_pkg;

    localparam int NUM_TAGS   = 4;
    localparam int FIFO_DEPTH = 4;

    typedef logic [3:0] cmd_t;
    typedef logic [1:0] resp_t;
    typedef logic [1:0] tag_t;

    // CALC3 command codes. The port forwards any code unchanged, so these
    // are reference values only.
    localparam cmd_t CMD_NOP   = 4'b0000;
    localparam cmd_t CMD_ADD   = 4'b0001;
    localparam cmd_t CMD_SUB   = 4'b0010;
    localparam cmd_t CMD_SHL   = 4'b0101;
    localparam cmd_t CMD_SHR   = 4'b0110;
    localparam cmd_t CMD_STORE = 4'b1001;
    localparam cmd_t CMD_FETCH = 4'b1010;

    // Response codes. Anything other than RESP_NONE counts as a response.
    localparam resp_t RESP_NONE = 2'b00;
    localparam resp_t RESP_OK   = 2'b01;
    localparam resp_t RESP_ERR  = 2'b10;
    localparam resp_t RESP_RSVD = 2'b11;

    // Request as driven onto the CALC3 request port.
    typedef struct packed {
        cmd_t        cmd;
        logic [3:0]  d1;
        logic [3:0]  d2;
        logic [3:0]  r1;
        logic [31:0] data;
        tag_t        tag;
    } req_rec_t;

    // Response as returned upstream; timeout=1 marks a synthesized entry
    // for a tag that never got an answer.
    typedef struct packed {
        resp_t       resp;
        logic [31:0] data;
        tag_t        tag;
        logic        timeout;
    } rsp_rec_t;

    // Index of the lowest set bit; 0 when none is set (callers qualify).
    function automatic tag_t lowest_set(input logic [NUM_TAGS-1:0] v);
        tag_t t;
        t = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (v[i]) t = tag_t'(i);
        end
        return t;
    endfunction

endpackage

// File: rtl/calc3_rsp_fifo.sv
// Four-entry first-word-fall-through FIFO for upstream responses.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   push_i, push_data_i  write an entry
//   pop_i                consume the head entry (ignored when empty)
//   head_o               head entry, forced to zero while empty
//   empty_o              no entries held
//   count_o              entries held, 0..4
module calc3_rsp_fifo
    import calc3_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  rsp_rec_t   push_data_i,
    input  logic       pop_i,
    output rsp_rec_t   head_o,
    output logic       empty_o,
    output logic [2:0] count_o
);

    rsp_rec_t   mem_q [FIFO_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop   = pop_i & (count_q != 3'd0);
        // A push at full is accepted only when the head leaves on the same edge.
        do_push  = push_i & ((count_q != 3'd4) | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + {2'b00, do_push} - {2'b00, do_pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign empty_o = (count_q == 3'd0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/calc3_req_port.sv
// Initiator end of one CALC3 port. Issues tagged requests, tracks which tags
// are outstanding, matches responses by tag, declares silent tags lost after
// TIMEOUT cycles, and returns responses upstream in arrival order.
// Ports:
//   c_clk, reset_n                     clock, asynchronous active-low reset
//   op_valid/op_ready, op_*            upstream operation handshake and fields
//   req_*                              CALC3 request port, one-cycle pulse per issue
//   out_resp, out_data, out_tag        CALC3 response port
//   rsp_valid/rsp_ready, rsp_*         upstream response handshake and record
//   err_spurious, err_timeout, err_clr sticky error flags and their clear
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; ready never depends on valid.
module calc3_req_port
    import calc3_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [3:0]  op_d1,
    input  logic [3:0]  op_d2,
    input  logic [3:0]  op_r1,
    input  logic [31:0] op_data,
    output logic [3:0]  req_cmd,
    output logic [3:0]  req_d1,
    output logic [3:0]  req_d2,
    output logic [3:0]  req_r1,
    output logic [31:0] req_data,
    output logic [1:0]  req_tag,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    input  logic [1:0]  out_tag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic        rsp_timeout,
    output logic        err_spurious,
    output logic        err_timeout,
    input  logic        err_clr
);

    localparam logic [7:0] TERM_AGE = 8'(TIMEOUT - 1);

    logic [NUM_TAGS-1:0] out_v_q, out_v_d;
    logic [7:0]          age_q [NUM_TAGS];
    logic [7:0]          age_d [NUM_TAGS];
    req_rec_t            req_q, req_d;
    logic                err_sp_q, err_sp_d;
    logic                err_to_q, err_to_d;

    logic [2:0]          out_cnt;
    logic [2:0]          fifo_cnt;
    logic                fifo_empty;
    rsp_rec_t            fifo_head;
    tag_t                alloc_tag, to_tag;
    logic                issue, resp_hit, spurious, to_fire, push;
    logic [NUM_TAGS-1:0] to_cand;
    rsp_rec_t            push_rec;

    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < NUM_TAGS; i++) out_cnt = out_cnt + 3'(out_v_q[i]);

        // Outstanding tags plus queued responses never exceed the FIFO depth,
        // so every response or timeout always has a slot to land in.
        op_ready  = reset_n & ~(&out_v_q)
                  & (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < 4'd4);
        issue     = op_valid & op_ready;
        alloc_tag = lowest_set(~out_v_q);

        resp_hit  = (out_resp != RESP_NONE) &  out_v_q[out_tag];
        spurious  = (out_resp != RESP_NONE) & ~out_v_q[out_tag];

        // A response push takes the FIFO slot this cycle; expired tags stay
        // parked at their terminal age and go out lowest-first on later cycles.
        // This also makes a same-cycle response win over its own timeout.
        for (int i = 0; i < NUM_TAGS; i++) to_cand[i] = out_v_q[i] & (age_q[i] == TERM_AGE);
        to_fire = (|to_cand) & ~resp_hit;
        to_tag  = lowest_set(to_cand);

        push     = resp_hit | to_fire;
        push_rec = resp_hit ? '{resp: out_resp, data: out_data, tag: out_tag, timeout: 1'b0}
                            : '{resp: RESP_NONE, data: 32'd0, tag: to_tag, timeout: 1'b1};

        out_v_d = out_v_q;
        if (resp_hit) out_v_d[out_tag] = 1'b0;
        if (to_fire)  out_v_d[to_tag]  = 1'b0;
        // Allocation came from the registered vector, so it never collides
        // with a tag being released on this edge.
        if (issue)    out_v_d[alloc_tag] = 1'b1;

        for (int i = 0; i < NUM_TAGS; i++) begin
            age_d[i] = age_q[i];
            if (out_v_q[i] && (age_q[i] != TERM_AGE)) age_d[i] = age_q[i] + 8'd1;
            if (issue && (alloc_tag == tag_t'(i)))   age_d[i] = '0;
        end

        req_d = '0;
        if (issue) begin
            req_d.cmd  = op_cmd;
            req_d.d1   = op_d1;
            req_d.d2   = op_d2;
            req_d.r1   = op_r1;
            req_d.data = op_data;
            req_d.tag  = alloc_tag;
        end

        // Setting beats clearing so an event in the clear cycle is not lost.
        err_sp_d = spurious ? 1'b1 : (err_clr ? 1'b0 : err_sp_q);
        err_to_d = to_fire  ? 1'b1 : (err_clr ? 1'b0 : err_to_q);
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_v_q  <= '0;
            for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= '0;
            req_q    <= '0;
            err_sp_q <= 1'b0;
            err_to_q <= 1'b0;
        end else begin
            out_v_q  <= out_v_d;
            for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= age_d[i];
            req_q    <= req_d;
            err_sp_q <= err_sp_d;
            err_to_q <= err_to_d;
        end
    end

    calc3_rsp_fifo u_rsp_fifo (
        .clk_i       (c_clk),
        .rst_ni      (reset_n),
        .push_i      (push),
        .push_data_i (push_rec),
        .pop_i       (rsp_ready),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    assign req_cmd      = req_q.cmd;
    assign req_d1       = req_q.d1;
    assign req_d2       = req_q.d2;
    assign req_r1       = req_q.r1;
    assign req_data     = req_q.data;
    assign req_tag      = req_q.tag;

    assign rsp_valid    = ~fifo_empty;
    assign rsp_resp     = fifo_head.resp;
    assign rsp_data     = fifo_head.data;
    assign rsp_tag      = fifo_head.tag;
    assign rsp_timeout  = fifo_head.timeout;

    assign err_spurious = err_sp_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_calc3_req_port.sv
module tb_calc3_req_port;

    localparam int TO = 8;

    // ---------------- clock / reset / DUT ----------------
    logic        c_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_cmd = '0, op_d1 = '0, op_d2 = '0, op_r1 = '0;
    logic [31:0] op_data = '0;
    logic [3:0]  req_cmd, req_d1, req_d2, req_r1;
    logic [31:0] req_data;
    logic [1:0]  req_tag;
    logic [1:0]  out_resp = '0;
    logic [31:0] out_data = '0;
    logic [1:0]  out_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tag;
    logic        rsp_timeout;
    logic        err_spurious, err_timeout;
    logic        err_clr = 1'b0;

    always #5 c_clk = ~c_clk;

    calc3_req_port #(.TIMEOUT(TO)) dut (
        .c_clk(c_clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_cmd(op_cmd), .op_d1(op_d1), .op_d2(op_d2), .op_r1(op_r1), .op_data(op_data),
        .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
        .req_data(req_data), .req_tag(req_tag),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
        .err_spurious(err_spurious), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    logic [49:0] req_bus;
    logic [37:0] rsp_bus;
    assign req_bus = {req_cmd, req_d1, req_d2, req_r1, req_data, req_tag};
    assign rsp_bus = {rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout};

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    // Tags are tracked by issue timestamp; a tag is lost once TO edges have
    // passed since it was issued. exp_q is the expected upstream response order.
    logic [36:0] exp_q[$];
    logic [3:0]  m_busy = '0;
    int          m_issue_cyc [4];
    logic [49:0] m_req = '0;
    logic        m_err_sp = 1'b0, m_err_to = 1'b0, m_issued = 1'b0;
    int          cyc = 0;

    function automatic logic m_ready_f();
        return reset_n && (m_busy != 4'hF) && (($countones(m_busy) + exp_q.size()) < 4);
    endfunction

    function automatic logic [37:0] exp_rsp();
        if (exp_q.size() > 0) return {1'b1, exp_q[0]};
        return 38'd0;
    endfunction

    task automatic model_reset();
        m_busy = '0; exp_q.delete(); m_req = '0;
        m_err_sp = 1'b0; m_err_to = 1'b0; m_issued = 1'b0; cyc = 0;
    endtask

    task automatic model_step();
        logic rdy, taken, sp, lost;
        int   free_t;
        if (!reset_n) begin
            model_reset();
            return;
        end
        cyc    = cyc + 1;
        rdy    = m_ready_f();
        free_t = 0;
        for (int t = 3; t >= 0; t--) if (!m_busy[t]) free_t = t;
        if (rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        taken = 1'b0; sp = 1'b0; lost = 1'b0;
        if (out_resp != 2'b00) begin
            if (m_busy[out_tag]) begin
                exp_q.push_back({out_resp, out_data, out_tag, 1'b0});
                m_busy[out_tag] = 1'b0;
                taken = 1'b1;
            end else sp = 1'b1;
        end
        if (!taken) begin
            for (int t = 0; t < 4; t++) begin
                if (!lost && m_busy[t] && (cyc - m_issue_cyc[t] >= TO)) begin
                    exp_q.push_back({2'b00, 32'd0, 2'(t), 1'b1});
                    m_busy[t] = 1'b0;
                    lost = 1'b1;
                end
            end
        end
        if (op_valid && rdy) begin
            m_busy[free_t]      = 1'b1;
            m_issue_cyc[free_t] = cyc;
            m_req    = {op_cmd, op_d1, op_d2, op_r1, op_data, 2'(free_t)};
            m_issued = 1'b1;
        end else begin
            m_req    = '0;
            m_issued = 1'b0;
        end
        m_err_sp = sp   ? 1'b1 : (err_clr ? 1'b0 : m_err_sp);
        m_err_to = lost ? 1'b1 : (err_clr ? 1'b0 : m_err_to);
    endtask

    // ---------------- drivers ----------------
    // Inputs change only at the negedge; outputs are sampled there too.
    task automatic tick();
        model_step();
        @(posedge c_clk);
        @(negedge c_clk);
    endtask

    task automatic drive_idle();
        op_valid = 1'b0; out_resp = 2'b00; err_clr = 1'b0;
    endtask

    task automatic drive_rand_op();
        op_valid = 1'b1;
        op_cmd = 4'($urandom_range(0, 15)); op_d1 = 4'($urandom_range(0, 15));
        op_d2  = 4'($urandom_range(0, 15)); op_r1 = 4'($urandom_range(0, 15));
        op_data = $urandom();
    endtask

    // ---------------- scenarios ----------------
    task automatic settle(input int n);
        drive_idle();
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++; if (rsp_bus !== exp_rsp()) $display("FAIL settle_rsp: got %h want %h", rsp_bus, exp_rsp()); else n_pass++;
            n_checks++; if (op_ready !== m_ready_f()) $display("FAIL settle_op_ready: got %b want %b", op_ready, m_ready_f()); else n_pass++;
        end
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL settle_empty: got %b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        tick(); tick();
        n_checks++; if (op_ready !== 1'b0) $display("FAIL reset_op_ready: got %b want 0", op_ready); else n_pass++;
        n_checks++; if (req_bus !== 50'd0) $display("FAIL reset_req: got %h want 0", req_bus); else n_pass++;
        n_checks++; if (rsp_bus !== 38'd0) $display("FAIL reset_rsp: got %h want 0", rsp_bus); else n_pass++;
        n_checks++; if ({err_spurious, err_timeout} !== 2'b00) $display("FAIL reset_err: got %b want 00", {err_spurious, err_timeout}); else n_pass++;
        reset_n = 1'b1;
        #1;
        n_checks++; if (op_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", op_ready); else n_pass++;
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        op_valid = 1'b1; op_cmd = 4'b0001; op_d1 = 4'd1; op_d2 = 4'd2; op_r1 = 4'd3; op_data = 32'd0;
        tick();
        op_valid = 1'b0;
        n_checks++; if (req_bus !== {4'd1, 4'd1, 4'd2, 4'd3, 32'd0, 2'd0}) $display("FAIL add_req: got %h want %h", req_bus, {4'd1, 4'd1, 4'd2, 4'd3, 32'd0, 2'd0}); else n_pass++;
        tick();
        n_checks++; if (req_bus !== 50'd0) $display("FAIL add_req_one_cycle: got %h want 0", req_bus); else n_pass++;
        out_resp = 2'b01; out_data = 32'd5; out_tag = 2'd0;
        tick();
        out_resp = 2'b00;
        n_checks++; if (rsp_bus !== {1'b1, 2'b01, 32'd5, 2'd0, 1'b0}) $display("FAIL add_rsp: got %h want %h", rsp_bus, {1'b1, 2'b01, 32'd5, 2'd0, 1'b0}); else n_pass++;
        n_checks++; if (rsp_bus !== exp_rsp()) $display("FAIL add_rsp_model: got %h want %h", rsp_bus, exp_rsp()); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL add_rsp_popped: got %b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int waited;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand_op();
            tick();
            n_checks++; if (req_tag !== 2'(i)) $display("FAIL b2b_tag%0d: got %0d want %0d", i, req_tag, i); else n_pass++;
            n_checks++; if (req_bus !== m_req) $display("FAIL b2b_req%0d: got %h want %h", i, req_bus, m_req); else n_pass++;
        end
        op_valid = 1'b0;
        n_checks++; if (op_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", op_ready); else n_pass++;
        out_resp = 2'b01; out_tag = 2'd2; out_data = $urandom();
        tick();
        out_resp = 2'b00;
        n_checks++; if ({rsp_valid, rsp_tag} !== 3'b110) $display("FAIL b2b_rsp_tag2: got %b want 110", {rsp_valid, rsp_tag}); else n_pass++;
        drive_rand_op();
        op_cmd = 4'b0010;
        waited = 0;
        while (waited < 6) begin
            tick();
            waited++;
            if (req_cmd !== 4'd0) break;
        end
        op_valid = 1'b0;
        n_checks++; if (waited >= 6) $display("FAIL b2b_reissue_timeout: got %0d cycles want <6", waited); else n_pass++;
        n_checks++; if (req_tag !== 2'd2) $display("FAIL b2b_reissue_tag: got %0d want 2", req_tag); else n_pass++;
        n_checks++; if (req_bus !== m_req) $display("FAIL b2b_reissue_req: got %h want %h", req_bus, m_req); else n_pass++;
        settle(20);
    endtask

    task automatic test_out_of_order();
        logic [1:0] order [4];
        order = '{2'd3, 2'd1, 2'd0, 2'd2};
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rand_op();
            tick();
        end
        op_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            out_resp = 2'($urandom_range(1, 3)); out_tag = order[k]; out_data = $urandom();
            tick();
        end
        out_resp = 2'b00;
        n_checks++; if (op_ready !== 1'b0) $display("FAIL ooo_full_ready: got %b want 0", op_ready); else n_pass++;
        n_checks++; if (rsp_bus !== exp_rsp()) $display("FAIL ooo_head: got %h want %h", rsp_bus, exp_rsp()); else n_pass++;
        tick();
        n_checks++; if ({rsp_valid, rsp_tag} !== 3'b111) $display("FAIL ooo_hold: got %b want 111", {rsp_valid, rsp_tag}); else n_pass++;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (rsp_tag !== order[k]) $display("FAIL ooo_order%0d: got %0d want %0d", k, rsp_tag, order[k]); else n_pass++;
            n_checks++; if (rsp_bus !== exp_rsp()) $display("FAIL ooo_rsp%0d: got %h want %h", k, rsp_bus, exp_rsp()); else n_pass++;
            tick();
        end
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL ooo_drained: got %b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_timeout();
        int cnt;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if ({err_spurious, err_timeout} !== 2'b00) $display("FAIL to_clr: got %b want 00", {err_spurious, err_timeout}); else n_pass++;
        rsp_ready = 1'b1;
        op_valid = 1'b1; op_cmd = 4'b0000; op_d1 = 4'hA; op_d2 = 4'h0; op_r1 = 4'h0; op_data = 32'd0;
        tick();
        op_valid = 1'b0;
        n_checks++; if (req_bus !== {4'h0, 4'hA, 4'h0, 4'h0, 32'd0, 2'd0}) $display("FAIL to_nop_req: got %h want %h", req_bus, {4'h0, 4'hA, 4'h0, 4'h0, 32'd0, 2'd0}); else n_pass++;
        cnt = 0;
        while (cnt < 20) begin
            tick();
            cnt++;
            if (rsp_valid === 1'b1) break;
        end
        n_checks++; if (cnt != TO) $display("FAIL to_latency: got %0d want %0d", cnt, TO); else n_pass++;
        n_checks++; if (rsp_bus !== {1'b1, 2'b00, 32'd0, 2'd0, 1'b1}) $display("FAIL to_entry: got %h want %h", rsp_bus, {1'b1, 2'b00, 32'd0, 2'd0, 1'b1}); else n_pass++;
        n_checks++; if (err_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", err_timeout); else n_pass++;
        out_resp = 2'b01; out_tag = 2'd0; out_data = $urandom();
        tick();
        out_resp = 2'b00;
        n_checks++; if (err_spurious !== 1'b1) $display("FAIL to_late_spurious: got %b want 1", err_spurious); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL to_late_nopush: got %b want 0", rsp_valid); else n_pass++;
        err_clr = 1'b1; out_resp = 2'b10; out_tag = 2'd0;
        tick();
        out_resp = 2'b00; err_clr = 1'b0;
        n_checks++; if ({err_spurious, err_timeout} !== 2'b10) $display("FAIL to_set_beats_clr: got %b want 10", {err_spurious, err_timeout}); else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err_spurious !== 1'b0) $display("FAIL to_final_clr: got %b want 0", err_spurious); else n_pass++;
    endtask

    task automatic test_spurious();
        rsp_ready = 1'b0;
        out_resp = 2'b01; out_tag = 2'd1; out_data = $urandom();
        tick();
        out_resp = 2'b00;
        n_checks++; if (err_spurious !== 1'b1) $display("FAIL sp_flag: got %b want 1", err_spurious); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL sp_nopush: got %b want 0", rsp_valid); else n_pass++;
        tick();
        n_checks++; if (err_spurious !== 1'b1) $display("FAIL sp_sticky: got %b want 1", err_spurious); else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err_spurious !== 1'b0) $display("FAIL sp_clr: got %b want 0", err_spurious); else n_pass++;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        drive_rand_op();
        out_resp = 2'b01; out_tag = 2'd3;
        tick();
        out_resp = 2'b00;
        drive_rand_op();
        op_cmd = 4'b1001;
        tick();
        op_valid = 1'b0;
        n_checks++; if (req_tag !== 2'd1) $display("FAIL rm_pre_tag: got %0d want 1", req_tag); else n_pass++;
        n_checks++; if (err_spurious !== 1'b1) $display("FAIL rm_pre_err: got %b want 1", err_spurious); else n_pass++;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (req_bus !== 50'd0) $display("FAIL rm_req_clear: got %h want 0", req_bus); else n_pass++;
        n_checks++; if ({op_ready, rsp_valid, err_spurious, err_timeout} !== 4'b0000) $display("FAIL rm_outs_clear: got %b want 0000", {op_ready, rsp_valid, err_spurious, err_timeout}); else n_pass++;
        @(negedge c_clk);
        reset_n = 1'b1;
        drive_rand_op();
        tick();
        op_valid = 1'b0;
        n_checks++; if (req_tag !== 2'd0) $display("FAIL rm_first_tag: got %0d want 0", req_tag); else n_pass++;
        n_checks++; if (req_bus !== m_req) $display("FAIL rm_first_req: got %h want %h", req_bus, m_req); else n_pass++;
        out_resp = 2'b01; out_tag = 2'd1; out_data = $urandom();
        tick();
        out_resp = 2'b00;
        n_checks++; if ({err_spurious, rsp_valid} !== 2'b10) $display("FAIL rm_stale_rsp: got %b want 10", {err_spurious, rsp_valid}); else n_pass++;
        settle(20);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_rand_op();
            op_valid  = ($urandom_range(0, 1) == 1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            out_resp  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            out_tag   = 2'($urandom_range(0, 3));
            out_data  = $urandom();
            err_clr   = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++; if (op_ready !== m_ready_f()) $display("FAIL rnd_op_ready c%0d: got %b want %b", c, op_ready, m_ready_f()); else n_pass++;
            n_checks++; if (req_bus !== m_req) $display("FAIL rnd_req c%0d: got %h want %h", c, req_bus, m_req); else n_pass++;
            n_checks++; if (rsp_bus !== exp_rsp()) $display("FAIL rnd_rsp c%0d: got %h want %h", c, rsp_bus, exp_rsp()); else n_pass++;
            n_checks++; if (err_spurious !== m_err_sp) $display("FAIL rnd_err_sp c%0d: got %b want %b", c, err_spurious, m_err_sp); else n_pass++;
            n_checks++; if (err_timeout !== m_err_to) $display("FAIL rnd_err_to c%0d: got %b want %b", c, err_timeout, m_err_to); else n_pass++;
        end
        settle(20);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge c_clk);
        test_reset();
        test_single_add();
        test_back_to_back();
        test_out_of_order();
        test_timeout();
        settle(4);
        test_spurious();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
